conv_output_serializer: RTL
===========================

CONV_OUTPUT_SERIALIZER -- requirements
Module: conv_output_serializer

Interface
REQ-001 Parameter WIDTH, default 32, bit width of one output pixel.
REQ-002 Parameter ARRAY_SIZE, default 6, number of pixels per captured row.
REQ-003 Parameter CAPTURE_DELAY, default 3, cycles from first STAGE_BIAS cycle to bus sample; legal range 1..7.
REQ-004 Parameter STAGE_BIAS, default 3'd5, encoding of the bias stage on current_state.
REQ-005 clk  input  1  clock, all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 current_state  input  3  conv controller stage code.
REQ-008 i_pixel_bus  input  ARRAY_SIZE*WIDTH  conv array outputs; element 0 is the most significant slice.
REQ-009 i_ready  input  1  downstream accepts o_pixel this cycle when high with o_valid.
REQ-010 o_pixel  output  WIDTH  current serialized pixel.
REQ-011 o_valid  output  1  o_pixel holds valid data.
REQ-012 o_col  output  3  index (0..ARRAY_SIZE-1) of o_pixel within its row.
REQ-013 o_row_done  output  1  one-cycle pulse on acceptance of the last element of a row.
REQ-014 o_overflow  output  1  sticky flag: a captured row was dropped.

Function
REQ-015 Bias entry detect: cycle N where current_state==STAGE_BIAS and it was not STAGE_BIAS in cycle N-1; repeated BIAS cycles produce no extra detects.
REQ-016 Each detect propagates through a CAPTURE_DELAY-stage shift register; i_pixel_bus is sampled on the clock edge ending cycle N+CAPTURE_DELAY.
REQ-017 Storage: one active row register (being streamed) and one pending row register, each ARRAY_SIZE*WIDTH.
REQ-018 FSM states IDLE and STREAM; reset state IDLE.
REQ-019 IDLE + capture: sample loads the active register, o_col=0, state->STREAM; o_valid high the next cycle.
REQ-020 STREAM: o_valid=1, o_pixel=active element o_col; element transfer occurs when o_valid && i_ready.
REQ-021 Transfer with o_col<ARRAY_SIZE-1: o_col increments; o_pixel holds stable while i_ready is low.
REQ-022 Transfer with o_col==ARRAY_SIZE-1: o_row_done pulses the same cycle; o_col wraps to 0; if pending full, pending moves to active and state stays STREAM, else state->IDLE and o_valid drops next cycle.
REQ-023 Capture in STREAM with pending empty: sample loads pending.
REQ-024 Capture in STREAM with pending full and no final-element transfer that cycle: sample dropped, o_overflow set and held until reset.
REQ-025 Capture coinciding with final-element transfer and pending full: pending->active, sample->pending, no overflow.
REQ-026 Capture coinciding with final-element transfer and pending empty: sample loads active directly, state stays STREAM, o_col=0.
REQ-027 Throughput: one pixel per cycle with i_ready held high; no bubble between back-to-back rows.
REQ-028 Latency: first pixel valid CAPTURE_DELAY+1 cycles after bias entry, with block idle.

Reset
REQ-029 rst_n low, regardless of clock or operation in progress: state=IDLE, o_valid=0, o_pixel=0, o_col=0, o_row_done=0, o_overflow=0, pending empty, delay shift register cleared; in-flight rows discarded.
REQ-030 First bias entry detect possible in the first cycle after rst_n deasserts.

Configuration
REQ-031 Macro CONV_OUT_RELU_EN defined: o_pixel forced to 0 when the selected element's bit WIDTH-1 is 1, else passed unchanged; combinational on the output, no added latency.
REQ-032 Macro CONV_OUT_RELU_EN undefined: o_pixel equals the stored element bit-exact.

Verification
REQ-033 Single row: bias entry at cycle 10, bus elements 1..6, i_ready=1 -> o_valid cycles 14..19, o_pixel 1,2,3,4,5,6, o_col 0..5, o_row_done at cycle 19.
REQ-034 Backpressure: i_ready low during cycles 15..17 of REQ-033 -> o_pixel=2 held stable, o_col=1, six transfers total, o_row_done at cycle 22.
REQ-035 Back-to-back: second bias entry 6 cycles after the first, bus 7..12 -> 12 contiguous valid cycles, pixels 1..12, two o_row_done pulses, o_overflow=0.
REQ-036 Overflow: i_ready=0, three bias entries 8 cycles apart -> rows 1 and 2 retained, row 3 dropped, o_overflow=1; after i_ready=1, output is row 1 then row 2 only.
REQ-037 ReLU: element 0 = 0xBF800000, element 1 = 0x00000005 -> with CONV_OUT_RELU_EN o_pixel 0x0 then 0x5; without it 0xBF800000 then 0x5.
REQ-038 Reset mid-stream: rst_n low for 2 cycles while o_col=3 -> all outputs 0 during reset; no further valid until the next bias entry.

Source files
------------

// File: rtl/conv_output_serializer.sv
// Captures a conv array output row a fixed delay after bias-stage entry and streams it one pixel per handshake.
// Optional build macro CONV_OUT_RELU_EN clamps negative output pixels to zero.
module conv_output_serializer #(
    parameter int         WIDTH         = 32,
    parameter int         ARRAY_SIZE    = 6,
    parameter int         CAPTURE_DELAY = 3,
    parameter logic [2:0] STAGE_BIAS    = 3'd5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2:0]                  current_state,
    input  logic [ARRAY_SIZE*WIDTH-1:0] i_pixel_bus,
    input  logic                        i_ready,
    output logic [WIDTH-1:0]            o_pixel,
    output logic                        o_valid,
    output logic [2:0]                  o_col,
    output logic                        o_row_done,
    output logic                        o_overflow
);

    localparam int         ROW_W    = ARRAY_SIZE * WIDTH;
    localparam logic [2:0] LAST_COL = 3'(ARRAY_SIZE - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                   state, state_nxt;
    logic                     bias_prev_p0;
    logic                     bias_entry;
    logic [CAPTURE_DELAY-1:0] bias_dly_p1;
    logic                     capture;
    logic [ROW_W-1:0]         active_row;
    logic [ROW_W-1:0]         pending_row;
    logic                     pend_full;
    logic [2:0]               col, col_nxt;
    logic                     overflow;
    logic                     xfer, last_xfer;
    logic                     load_active_bus, load_active_pend, load_pend, pend_clr, ovf_set;
    logic [WIDTH-1:0]         elem;

`ifdef CONV_OUT_RELU_EN
    function automatic logic [WIDTH-1:0] relu(input logic signed [WIDTH-1:0] x);
        return (x < 0) ? '0 : x;
    endfunction
`endif

    // Stage p0: bias entry edge detect
    assign bias_entry = (current_state == STAGE_BIAS) && !bias_prev_p0;
    assign capture    = bias_dly_p1[CAPTURE_DELAY-1];

    // Stage p1: capture delay line, its last tap marks the bus sample edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_prev_p0 <= 1'b0;
            bias_dly_p1  <= '0;
        end else begin
            bias_prev_p0   <= (current_state == STAGE_BIAS);
            bias_dly_p1[0] <= bias_entry;
            for (int i = 1; i < CAPTURE_DELAY; i++) begin
                bias_dly_p1[i] <= bias_dly_p1[i-1];
            end
        end
    end

    assign xfer      = (state == STREAM) && i_ready;
    assign last_xfer = xfer && (col == LAST_COL);

    always_comb begin
        state_nxt        = state;
        col_nxt          = col;
        load_active_bus  = 1'b0;
        load_active_pend = 1'b0;
        load_pend        = 1'b0;
        pend_clr         = 1'b0;
        ovf_set          = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nxt       = STREAM;
                    load_active_bus = 1'b1;
                    col_nxt         = 3'd0;
                end
            end
            STREAM: begin
                if (last_xfer) begin
                    col_nxt = 3'd0;
                    if (pend_full) begin
                        // Pending row promotes; a simultaneous capture refills the freed slot
                        load_active_pend = 1'b1;
                        if (capture) load_pend = 1'b1;
                        else         pend_clr  = 1'b1;
                    end else if (capture) begin
                        load_active_bus = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    if (xfer) col_nxt = col + 3'd1;
                    if (capture) begin
                        if (pend_full) ovf_set   = 1'b1;
                        else           load_pend = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p2: control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= 3'd0;
            pend_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            if (load_pend)     pend_full <= 1'b1;
            else if (pend_clr) pend_full <= 1'b0;
            if (ovf_set) overflow <= 1'b1;
        end
    end

    // Row storage is qualified by the control path and needs no reset
    always_ff @(posedge clk) begin
        if (load_active_bus)       active_row <= i_pixel_bus;
        else if (load_active_pend) active_row <= pending_row;
        if (load_pend) pending_row <= i_pixel_bus;
    end

    // Element 0 sits in the most significant slice of the row
    always_comb begin
        elem = active_row[(ARRAY_SIZE - 1 - int'(col)) * WIDTH +: WIDTH];
    end

    assign o_valid    = (state == STREAM);
    assign o_col      = col;
    assign o_row_done = last_xfer;
    assign o_overflow = overflow;

`ifdef CONV_OUT_RELU_EN
    assign o_pixel = o_valid ? relu(elem) : '0;
`else
    assign o_pixel = o_valid ? elem : '0;
`endif

endmodule
